// File: rtl/unidad_control_segmentada.sv
// Pipelined MIPS main control: decodes in ID and carries WB/M/EX bundles through ID/EX, EX/MEM, MEM/WB.
// Load-use hazards stall one cycle with a bubble; taken BEQ/BNE resolve in MEM and flush the younger stages.
module unidad_control_segmentada #(
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 3,
   parameter bit ENABLE_BNE = 1'b1,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            opcode,
   input  logic [REG_ADDR_W-1:0] rs_id,
   input  logic [REG_ADDR_W-1:0] rt_id,
   input  logic                  zero_mem,
   output logic [ALUOP_W+1:0]    ex_ctrl,
   output logic [2:0]            m_ctrl,
   output logic [1:0]            wb_ctrl,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  pc_src,
   output logic                  ilegal_ex,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   logic                  reg_write, mem_to_reg, branch, mem_read, mem_write, reg_dst, alu_src;
   logic [ALUOP_W-1:0]    alu_op;
   logic                  bne_id, illegal_id;
   logic [ALUOP_W+1:0]    ex_id;
   logic [2:0]            m_id;
   logic [1:0]            wb_id;

   logic [ALUOP_W+1:0]    ex_ex;
   logic [2:0]            m_ex, m_mem;
   logic [1:0]            wb_ex, wb_mem, wb_wb;
   logic [REG_ADDR_W-1:0] rt_ex;
   logic                  bne_ex, bne_mem, ill_ex;
   logic                  stall, flush, stall_eff;

   always_comb begin
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = '0;
      bne_id     = 1'b0;
      illegal_id = 1'b0;
      case (opcode)
         6'b000000: begin reg_write = 1'b1; reg_dst = 1'b1; alu_op = ALUOP_W'(3'b010); end
         6'b100011: begin reg_write = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1; alu_src = 1'b1; end
         6'b101011: begin mem_write = 1'b1; alu_src = 1'b1; end
         6'b000100: begin branch = 1'b1; alu_op = ALUOP_W'(3'b001); end
         6'b000101: begin
            if (ENABLE_BNE) begin
               branch = 1'b1;
               bne_id = 1'b1;
               alu_op = ALUOP_W'(3'b001);
            end else begin
               illegal_id = 1'b1;
            end
         end
         6'b001000: begin reg_write = 1'b1; alu_src = 1'b1; end
         6'b001010: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_W'(3'b011); end
         6'b001100: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_W'(3'b100); end
         6'b001101: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = ALUOP_W'(3'b101); end
         default:   illegal_id = 1'b1;
      endcase
      ex_id = {alu_src, alu_op, reg_dst};
      m_id  = {mem_write, mem_read, branch};
      wb_id = {mem_to_reg, reg_write};
   end

   // A taken branch kills the stalled instruction anyway, so it overrides the stall.
   assign stall      = m_ex[1] && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
   assign pc_src     = m_mem[0] & (zero_mem ^ bne_mem);
   assign flush      = pc_src;
   assign stall_eff  = stall & ~flush;
   assign pc_write   = ~stall_eff;
   assign ifid_write = ~stall_eff;
   assign ifid_flush = flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ex   <= '0;
         m_ex    <= '0;
         wb_ex   <= '0;
         rt_ex   <= '0;
         bne_ex  <= 1'b0;
         ill_ex  <= 1'b0;
         m_mem   <= '0;
         wb_mem  <= '0;
         bne_mem <= 1'b0;
         wb_wb   <= '0;
      end else begin
         if (flush || stall_eff) begin
            ex_ex  <= '0;
            m_ex   <= '0;
            wb_ex  <= '0;
            rt_ex  <= '0;
            bne_ex <= 1'b0;
            ill_ex <= 1'b0;
         end else begin
            ex_ex  <= ex_id;
            m_ex   <= m_id;
            wb_ex  <= wb_id;
            rt_ex  <= rt_id;
            bne_ex <= bne_id;
            ill_ex <= illegal_id;
         end
         if (flush) begin
            m_mem   <= '0;
            wb_mem  <= '0;
            bne_mem <= 1'b0;
         end else begin
            m_mem   <= m_ex;
            wb_mem  <= wb_ex;
            bne_mem <= bne_ex;
         end
         wb_wb <= wb_mem;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_eff && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign ex_ctrl   = ex_ex;
   assign m_ctrl    = m_mem;
   assign wb_ctrl   = wb_wb;
   assign ilegal_ex = ill_ex;

endmodule

// File: tb/tb_unidad_control_segmentada.sv
// Directed bench: main instance (BNE enabled, 16-bit counters) and a second (BNE illegal, 2-bit counters) on shared inputs.
module tb_unidad_control_segmentada;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   logic        clk, rst_n, zero_mem;
   logic [5:0]  opcode;
   logic [4:0]  rs_id, rt_id;

   logic [4:0]  ex_ctrl, b_ex_ctrl;
   logic [2:0]  m_ctrl, b_m_ctrl;
   logic [1:0]  wb_ctrl, b_wb_ctrl;
   logic        pc_write, ifid_write, ifid_flush, pc_src, ilegal_ex;
   logic        b_pc_write, b_ifid_write, b_ifid_flush, b_pc_src, b_ilegal_ex;
   logic [15:0] stall_cnt, flush_cnt;
   logic [1:0]  b_stall_cnt, b_flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   unidad_control_segmentada #(.REG_ADDR_W(5), .ALUOP_W(3), .ENABLE_BNE(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .rs_id(rs_id), .rt_id(rt_id), .zero_mem(zero_mem),
      .ex_ctrl(ex_ctrl), .m_ctrl(m_ctrl), .wb_ctrl(wb_ctrl), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush), .pc_src(pc_src), .ilegal_ex(ilegal_ex),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   unidad_control_segmentada #(.REG_ADDR_W(5), .ALUOP_W(3), .ENABLE_BNE(1'b0), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .rs_id(rs_id), .rt_id(rt_id), .zero_mem(zero_mem),
      .ex_ctrl(b_ex_ctrl), .m_ctrl(b_m_ctrl), .wb_ctrl(b_wb_ctrl), .pc_write(b_pc_write),
      .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush), .pc_src(b_pc_src), .ilegal_ex(b_ilegal_ex),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      opcode   = OP_R;
      rs_id    = '0;
      rt_id    = '0;
      zero_mem = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [5:0] ops    [7];
   logic [4:0] exp_ex [7];
   logic [2:0] exp_m  [7];
   logic [1:0] exp_wb [7];

   initial begin
      ops    = '{OP_R, OP_LW, OP_SW, OP_ORI, OP_ADDI, OP_SLTI, OP_ANDI};
      exp_ex = '{5'h05, 5'h10, 5'h10, 5'h1A, 5'h10, 5'h16, 5'h18};
      exp_m  = '{3'b000, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
      exp_wb = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};

      // reset values
      rst_n = 1'b0; opcode = OP_LW; rs_id = '0; rt_id = '0; zero_mem = 1'b0;
      #1;
      check("rst_ex", ex_ctrl, 0);
      check("rst_m", m_ctrl, 0);
      check("rst_wb", wb_ctrl, 0);
      check("rst_ill", ilegal_ex, 0);
      check("rst_pcsrc", pc_src, 0);
      check("rst_flush", ifid_flush, 0);
      check("rst_pcw", pc_write, 1);
      check("rst_ifidw", ifid_write, 1);
      check("rst_scnt", stall_cnt, 0);
      check("rst_fcnt", flush_cnt, 0);
      tick();
      do_reset();

      // decode and stage latencies
      for (int i = 0; i < 7; i++) begin
         opcode = ops[i];
         tick();
         check($sformatf("dec_ex%0d", i), ex_ctrl, exp_ex[i]);
         if (i >= 1) check($sformatf("dec_m%0d", i), m_ctrl, exp_m[i-1]);
         if (i >= 2) check($sformatf("dec_wb%0d", i), wb_ctrl, exp_wb[i-2]);
      end
      rst_n = 1'b0;
      #1;
      check("midrst_ex", ex_ctrl, 0);
      check("midrst_m", m_ctrl, 0);
      check("midrst_wb", wb_ctrl, 0);
      do_reset();

      // load-use with rt=8
      opcode = OP_LW; rt_id = 5'd8;
      tick();
      opcode = OP_R; rs_id = 5'd8; rt_id = 5'd9;
      #1;
      check("lu_pcw", pc_write, 0);
      check("lu_ifidw", ifid_write, 0);
      check("lu_ex_lw", ex_ctrl, 5'h10);
      tick();
      check("lu_bubble", ex_ctrl, 0);
      check("lu_m_lw", m_ctrl, 3'b010);
      check("lu_pcw_after", pc_write, 1);
      check("lu_scnt", stall_cnt, 1);
      tick();
      check("lu_ex_r", ex_ctrl, 5'h05);
      check("lu_m_bubble", m_ctrl, 0);
      check("lu_scnt_hold", stall_cnt, 1);

      // load-use with rt=0 never stalls
      do_reset();
      opcode = OP_LW; rt_id = 5'd0;
      tick();
      opcode = OP_R; rs_id = 5'd0; rt_id = 5'd0;
      #1;
      check("lu0_pcw", pc_write, 1);
      tick();
      check("lu0_ex", ex_ctrl, 5'h05);
      check("lu0_scnt", stall_cnt, 0);

      // back-to-back dependent loads
      do_reset();
      opcode = OP_LW; rt_id = 5'd8;
      tick();
      opcode = OP_LW; rs_id = 5'd8; rt_id = 5'd9;
      #1;
      check("b2b_stall1", pc_write, 0);
      tick();
      check("b2b_nostall", pc_write, 1);
      tick();
      opcode = OP_R; rs_id = 5'd9; rt_id = 5'd0;
      #1;
      check("b2b_stall2", ifid_write, 0);
      tick();
      check("b2b_scnt", stall_cnt, 2);

      // BEQ taken
      do_reset();
      opcode = OP_BEQ;
      tick();
      check("beq_ex", ex_ctrl, 5'h02);
      opcode = OP_R;
      tick();
      check("beq_m", m_ctrl, 3'b001);
      opcode = OP_ADDI; zero_mem = 1'b1;
      #1;
      check("beq_pcsrc", pc_src, 1);
      check("beq_flush", ifid_flush, 1);
      tick();
      opcode = OP_ORI;
      check("beq_ex_zero", ex_ctrl, 0);
      check("beq_m_zero", m_ctrl, 0);
      check("beq_wb", wb_ctrl, 0);
      check("beq_pcsrc_off", pc_src, 0);
      check("beq_flush_off", ifid_flush, 0);
      check("beq_fcnt", flush_cnt, 1);
      tick();
      check("beq_m_zero2", m_ctrl, 0);
      check("beq_ex_tgt", ex_ctrl, 5'h1A);

      // BEQ not taken
      do_reset();
      opcode = OP_BEQ;
      tick();
      opcode = OP_R;
      tick();
      opcode = OP_ADDI; zero_mem = 1'b0;
      #1;
      check("beqn_pcsrc", pc_src, 0);
      check("beqn_flush", ifid_flush, 0);
      tick();
      check("beqn_ex", ex_ctrl, 5'h10);
      check("beqn_m", m_ctrl, 0);
      check("beqn_fcnt", flush_cnt, 0);

      // BNE enabled vs. illegal
      do_reset();
      opcode = OP_BNE;
      tick();
      check("bne_ex", ex_ctrl, 5'h02);
      check("bne_ill", ilegal_ex, 0);
      check("bneoff_ill", b_ilegal_ex, 1);
      check("bneoff_ex", b_ex_ctrl, 0);
      opcode = OP_R;
      tick();
      zero_mem = 1'b0;
      #1;
      check("bne_m", m_ctrl, 3'b001);
      check("bne_pcsrc", pc_src, 1);
      check("bneoff_m", b_m_ctrl, 0);
      check("bneoff_pcsrc", b_pc_src, 0);
      check("bneoff_ill_gone", b_ilegal_ex, 0);
      tick();
      check("bne_fcnt", flush_cnt, 1);
      check("bneoff_fcnt", b_flush_cnt, 0);
      check("bneoff_wb", b_wb_ctrl, 0);

      // flush and stall in the same cycle
      do_reset();
      opcode = OP_BEQ;
      tick();
      opcode = OP_LW; rt_id = 5'd8;
      tick();
      opcode = OP_R; rs_id = 5'd8; rt_id = 5'd0; zero_mem = 1'b1;
      #1;
      check("sim_pcsrc", pc_src, 1);
      check("sim_pcw", pc_write, 1);
      check("sim_ifidw", ifid_write, 1);
      check("sim_flush", ifid_flush, 1);
      tick();
      check("sim_scnt", stall_cnt, 0);
      check("sim_fcnt", flush_cnt, 1);
      check("sim_ex", ex_ctrl, 0);
      check("sim_m", m_ctrl, 0);

      // counter saturation on the 2-bit instance
      do_reset();
      opcode = OP_LW; rt_id = 5'd8;
      tick();
      rs_id = 5'd8;
      for (int i = 0; i < 10; i++) tick();
      check("sat_scnt16", stall_cnt, 5);
      check("sat_scnt2", b_stall_cnt, 3);
      for (int i = 0; i < 4; i++) tick();
      check("sat_scnt16_more", stall_cnt, 7);
      check("sat_scnt2_hold", b_stall_cnt, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/unidad_control_segmentada.md
# unidad_control_segmentada

Pipelined main control for the five-stage MIPS datapath. Decodes the opcode in ID and carries the WB/M/EX control bundles through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards (stall plus bubble) and resolves BEQ/BNE in MEM (flushes the younger instructions). Saturating counters record stall and flush events for performance measurement.

## Interface
- REG_ADDR_W, 5, register-address width
- ALUOP_W, 3, ALUOp field width; must be ≥3, codes zero-extended
- ENABLE_BNE, 1, 1 = decode opcode 000101 as BNE; 0 = treat it as illegal
- CNT_W, 16, width of the stall and flush counters

- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- OPCODE  in  6  IF/ID instruction[31:26]
- RS_ID  in  REG_ADDR_W  IF/ID rs field
- RT_ID  in  REG_ADDR_W  IF/ID rt field
- ZERO_MEM  in  1  ALU zero flag of the instruction in MEM
- EX_CTRL  out  ALUOP_W+2  ID/EX bundle: [0] RegDst, [ALUOP_W:1] ALUOp, [ALUOP_W+1] ALUSrc
- M_CTRL  out  3  EX/MEM bundle: [0] Branch, [1] MemRead, [2] MemWrite
- WB_CTRL  out  2  MEM/WB bundle: [0] RegWrite, [1] MemToReg
- PC_WRITE  out  1  0 = hold PC
- IFID_WRITE  out  1  0 = hold IF/ID
- IFID_FLUSH  out  1  1 = zero IF/ID on the next edge
- PC_SRC  out  1  1 = PC loads the branch target
- ILEGAL_EX  out  1  the instruction now in EX had an undecoded opcode
- STALL_CNT, FLUSH_CNT  out  CNT_W  saturating event counters

## Operation
- Decode (combinational, ID stage), listed as RegWrite, MemToReg, Branch, MemRead, MemWrite, RegDst, ALUOp, ALUSrc:
  - R-type 000000: 1,0,0,0,0,1,010,0
  - LW 100011: 1,1,0,1,0,0,000,1
  - SW 101011: 0,0,0,0,1,0,000,1
  - BEQ 000100: 0,0,1,0,0,0,001,0
  - BNE 000101: same as BEQ, plus an internal bne bit
  - ADDI 001000: 1,0,0,0,0,0,000,1
  - SLTI 001010: 1,0,0,0,0,0,011,1
  - ANDI 001100: 1,0,0,0,0,0,100,1
  - ORI 001101: 1,0,0,0,0,0,101,1
- No don't-cares: every unlisted bit is 0.
- Any other opcode decodes to an all-zero bundle with the illegal bit set; the illegal bit travels in ID/EX.
- ID/EX also stores the ID-stage rt field as rt_ex. EX/MEM stores the bne bit.
- Load-use stall condition: ID/EX MemRead=1, rt_ex≠0, and (rt_ex==RS_ID or rt_ex==RT_ID).
  - PC_WRITE=0, IFID_WRITE=0.
  - An all-zero bubble (illegal bit 0) is loaded into ID/EX.
- Branch taken: PC_SRC = M_CTRL[0] & (ZERO_MEM ^ bne_mem).
  - IFID_FLUSH=1.
  - ID/EX and EX/MEM load all-zero bundles on the next edge.
  - MEM/WB loads normally.
- Flush and stall in the same cycle: flush wins. PC_WRITE=1, IFID_WRITE=1, IFID_FLUSH=1, no stall counted.
- STALL_CNT increments once per stall cycle. FLUSH_CNT increments once per taken branch. Both saturate at 2^CNT_W−1 (no wrap).

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - All bundle registers, rt_ex, bne and illegal bits = 0.
  - EX_CTRL=0, M_CTRL=0, WB_CTRL=0, ILEGAL_EX=0, PC_SRC=0, IFID_FLUSH=0.
  - PC_WRITE=1, IFID_WRITE=1, counters=0.
- Reset mid-operation discards all in-flight bundles immediately. No partial state survives.
- Latency from OPCODE in ID: EX_CTRL +1 edge, M_CTRL +2 edges, WB_CTRL +3 edges.
- PC_WRITE, IFID_WRITE, IFID_FLUSH and PC_SRC are combinational from the stage registers, RS_ID, RT_ID and ZERO_MEM, valid within the same cycle.
- A load-use stall lasts exactly one cycle: the bubble clears ID/EX MemRead.
- Back-to-back LW each trigger their own stall if dependent.
- Taken-branch cost is 3 cycles. The branch itself completes in WB with RegWrite=0.

## Test plan
- Reset and decode: reset, then OPCODE=000000, 100011, 101011, 001101 on consecutive cycles. EX_CTRL must show 0x05, 0x10, 0x10, 0x1A one edge later each. WB_CTRL must show 01, 11, 00, 01 three edges later each. Assert RST_N=0 mid-stream: all bundles are 0 immediately.
- Load-use: LW with rt=8 in ID, then R-type with RS_ID=8. Required: one cycle of PC_WRITE=0, IFID_WRITE=0; a bubble (EX_CTRL=0) follows the LW in EX; STALL_CNT=1. Repeat with rt=0: no stall.
- BEQ taken: BEQ with ZERO_MEM=1 when it reaches MEM. PC_SRC=1 and IFID_FLUSH=1 for one cycle. The next two EX_CTRL/M_CTRL values are 0. FLUSH_CNT=1. With ZERO_MEM=0: no flush.
- BNE: ENABLE_BNE=1, ZERO_MEM=0 → PC_SRC=1. ENABLE_BNE=0 → ILEGAL_EX=1 one edge after decode, all bundles 0, never branches.
- Simultaneous events: a taken branch in MEM while the stall condition holds in ID. PC_WRITE=1, IFID_FLUSH=1, STALL_CNT unchanged.
- Saturation: CNT_W=2, force 5 stalls. STALL_CNT reads 3 and stays at 3.
